// File: rtl/gate_id_pkg.sv
// Shared types and constants for the gate identifier.
// State encoding, gate_id codes and reference truth tables.
package gate_id_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] ID_NOT     = 3'd0;
   localparam logic [2:0] ID_AND     = 3'd1;
   localparam logic [2:0] ID_OR      = 3'd2;
   localparam logic [2:0] ID_NAND    = 3'd3;
   localparam logic [2:0] ID_NOR     = 3'd4;
   localparam logic [2:0] ID_XOR     = 3'd5;
   localparam logic [2:0] ID_XNOR    = 3'd6;
   localparam logic [2:0] ID_UNKNOWN = 3'd7;

   // truth[v] is the response to vector v = {a, b}
   localparam logic [3:0] TT_NOT  = 4'b0011;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_identifier_if.sv
// Bundle between gate_identifier and its user / gate under test.
// The truth field exists only when GATE_ID_TRUTH_EN is defined.
interface gate_identifier_if;

   logic       start;
   logic       y_in;
   logic       a_out;
   logic       b_out;
   logic       busy;
   logic       done;
   logic [2:0] gate_id;
   logic       match;
`ifdef GATE_ID_TRUTH_EN
   logic [3:0] truth;

   modport slave (
      input  start, y_in,
      output a_out, b_out, busy, done,
      output gate_id, match, truth
   );

   modport master (
      output start, y_in,
      input  a_out, b_out, busy, done,
      input  gate_id, match, truth
   );
`else
   modport slave (
      input  start, y_in,
      output a_out, b_out, busy, done,
      output gate_id, match
   );

   modport master (
      output start, y_in,
      input  a_out, b_out, busy, done,
      input  gate_id, match
   );
`endif

endinterface

// File: rtl/gate_classifier.sv
// Combinational decoder from a 4-entry truth table to a gate code.
// Unlisted tables decode to ID_UNKNOWN with match low.
module gate_classifier
   import gate_id_pkg::*;
(
   input  logic [3:0] truth,
   output logic [2:0] gate_id,
   output logic       match
);

   // Map each known truth table onto its function code
   always_comb begin
      gate_id = ID_UNKNOWN;
      case (truth)
         TT_NOT:  gate_id = ID_NOT;
         TT_AND:  gate_id = ID_AND;
         TT_OR:   gate_id = ID_OR;
         TT_NAND: gate_id = ID_NAND;
         TT_NOR:  gate_id = ID_NOR;
         TT_XOR:  gate_id = ID_XOR;
         TT_XNOR: gate_id = ID_XNOR;
         default: gate_id = ID_UNKNOWN;
      endcase
      match = (gate_id != ID_UNKNOWN);
   end

endmodule

// File: rtl/gate_identifier.sv
// Sweeps a two-input gate through all vectors and classifies it.
// Define GATE_ID_TRUTH_EN to expose the captured truth table.
module gate_identifier
   import gate_id_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               rst,
   gate_identifier_if.slave   bus
);

   localparam logic [7:0] LAST = 8'(SETTLE - 1);

   state_t     state;
   logic [1:0] v;
   logic [7:0] cnt;
   logic [2:0] cap;
   logic [2:0] id_c;
   logic       match_c;

   // Final vector's sample joins the three already captured
   gate_classifier u_cls (
      .truth   ({bus.y_in, cap}),
      .gate_id (id_c),
      .match   (match_c)
   );

   // Sweep FSM with vector/settle counters and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         v           <= 2'd0;
         cnt         <= 8'd0;
         cap         <= 3'd0;
         bus.a_out   <= 1'b0;
         bus.b_out   <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.gate_id <= ID_UNKNOWN;
         bus.match   <= 1'b0;
`ifdef GATE_ID_TRUTH_EN
         bus.truth   <= 4'd0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state     <= APPLY;
                  v         <= 2'd0;
                  cnt       <= 8'd0;
                  bus.busy  <= 1'b1;
                  bus.a_out <= 1'b0;
                  bus.b_out <= 1'b0;
               end
            end
            APPLY: begin
               if (cnt == LAST) begin
                  cnt <= 8'd0;
                  if (v != 2'd3) begin
                     cap <= {bus.y_in, cap[2:1]};
                     v   <= v + 2'd1;
                     {bus.a_out, bus.b_out} <= v + 2'd1;
                  end else begin
                     state       <= DONE;
                     bus.gate_id <= id_c;
                     bus.match   <= match_c;
`ifdef GATE_ID_TRUTH_EN
                     bus.truth   <= {bus.y_in, cap};
`endif
                     bus.busy    <= 1'b0;
                     bus.done    <= 1'b1;
                     bus.a_out   <= 1'b0;
                     bus.b_out   <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
